// File: rtl/fet_scan_ctrl.sv
// FET channel scan sequencer: steps the decoder select code through a channel
// range with a break-before-make gap, a settle delay and a req/ack measurement.
module fet_scan_ctrl #(
  parameter int SEL_W    = 5,
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [SEL_W-1:0]    ch_first,
  input  logic [SEL_W-1:0]    ch_last,
  input  logic [SETTLE_W-1:0] settle,
  input  logic                meas_ack,
  output logic [SEL_W-1:0]    sel,
  output logic                sel_en,
  output logic                meas_req,
  output logic                ch_done,
  output logic [SEL_W-1:0]    ch_idx,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {IDLE, GAP, SETTLE, MEAS} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    first_q, first_d, last_q, last_d;
  logic [SEL_W-1:0]    sel_q, sel_d, ch_idx_q, ch_idx_d;
  logic [SETTLE_W-1:0] settle_q, settle_d, cnt_q, cnt_d;
  logic                cont_q, cont_d, stop_pend_q, stop_pend_d;
  logic                sel_en_q, sel_en_d, meas_req_q, meas_req_d;
  logic                ch_done_q, ch_done_d, busy_q, busy_d, done_q, done_d;
  logic                stop_eff;

  // Handshake: meas_req stays high until meas_ack is sampled high on a rising
  // edge in MEAS; meas_req drops on that same edge and ack is ignored elsewhere.
  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    last_d      = last_q;
    settle_d    = settle_q;
    cont_d      = cont_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    ch_idx_d    = ch_idx_q;
    ch_done_d   = 1'b0;
    done_d      = 1'b0;
    stop_eff    = stop_pend_q | stop;
    stop_pend_d = stop_eff;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          first_d  = ch_first;
          last_d   = ch_last;
          settle_d = settle;
          cont_d   = continuous;
          sel_d    = ch_first;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (stop_eff) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = settle_q;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (stop_eff) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = MEAS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MEAS: begin
        if (meas_ack) begin
          ch_done_d = 1'b1;
          ch_idx_d  = sel_q;
          if ((sel_q == last_q && !cont_q) || stop_eff) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (sel_q == last_q) begin
            sel_d   = first_q;
            state_d = GAP;
          end else begin
            sel_d   = sel_q + 1'b1;
            state_d = GAP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) stop_pend_d = 1'b0;
    // Output flops follow the next state so they line up with state_q.
    sel_en_d   = (state_d == SETTLE) || (state_d == MEAS);
    meas_req_d = (state_d == MEAS);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      first_q     <= '0;
      last_q      <= '0;
      settle_q    <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      cnt_q       <= '0;
      sel_q       <= '0;
      ch_idx_q    <= '0;
      sel_en_q    <= 1'b0;
      meas_req_q  <= 1'b0;
      ch_done_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      last_q      <= last_d;
      settle_q    <= settle_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      ch_idx_q    <= ch_idx_d;
      sel_en_q    <= sel_en_d;
      meas_req_q  <= meas_req_d;
      ch_done_q   <= ch_done_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sel       = sel_q;
  assign sel_en    = sel_en_q;
  assign meas_req  = meas_req_q;
  assign ch_done   = ch_done_q;
  assign ch_idx    = ch_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fet_scan_ctrl.sv
// Directed bench for fet_scan_ctrl: sweeps, wrap, continuous stop, aborts,
// ignore cases, async reset and a break-before-make monitor.
module tb_fet_scan_ctrl;

  logic       clk, rst_n, start, stop, continuous, meas_ack;
  logic [4:0] ch_first, ch_last, sel, ch_idx;
  logic [7:0] settle;
  logic       sel_en, meas_req, ch_done, busy, done;
  logic [1:0] state_dbg;

  logic       ack_auto, ack_man, auto_ack;
  int         ack_delay, req_w;
  assign meas_ack = ack_auto | ack_man;

  fet_scan_ctrl #(.SEL_W(5), .SETTLE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .continuous(continuous), .ch_first(ch_first), .ch_last(ch_last),
    .settle(settle), .meas_ack(meas_ack), .sel(sel), .sel_en(sel_en),
    .meas_req(meas_req), .ch_done(ch_done), .ch_idx(ch_idx), .busy(busy),
    .done(done), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks, n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [23:0] tim_q[$];
  logic [7:0]  gap_c, set_c, meas_c;
  int          done_c, busy_c, req_seen, bbm_err;
  logic        prev_en;
  logic [4:0]  prev_sel;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: sample on the falling edge, update monitors, run the ack responder.
  task automatic tick();
    @(negedge clk);
    if (sel_en && prev_en && sel != prev_sel) bbm_err++;
    prev_en  = sel_en;
    prev_sel = sel;
    if (ch_done) begin
      got_q.push_back(32'(ch_idx));
      tim_q.push_back({gap_c, set_c, meas_c});
      gap_c = 0; set_c = 0; meas_c = 0;
    end
    if (done) done_c++;
    if (busy) busy_c++;
    if (busy && !sel_en) gap_c++;
    if (sel_en && !meas_req) set_c++;
    if (meas_req) begin meas_c++; req_seen++; end
    if (auto_ack && meas_req && !ack_auto) begin
      req_w++;
      if (req_w >= ack_delay) begin ack_auto = 1'b1; req_w = 0; end
    end else begin
      ack_auto = 1'b0;
      req_w    = 0;
    end
  endtask

  task automatic start_sweep(input logic [4:0] f, input logic [4:0] l, input logic [7:0] s,
                             input logic c, input int d);
    got_q.delete(); tim_q.delete();
    gap_c = 0; set_c = 0; meas_c = 0;
    done_c = 0; busy_c = 0; req_seen = 0; bbm_err = 0;
    ch_first = f; ch_last = l; settle = s; continuous = c;
    ack_delay = d; auto_ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    while (done_c == 0 && n < bound) begin tick(); n++; end
    check_eq({tag, "_done_cnt"}, done_c, 1);
  endtask

  task automatic check_got(input string tag);
    check_eq({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq({tag, "_idx"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    int n, base;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; start = 0; stop = 0; continuous = 0;
    ch_first = 0; ch_last = 0; settle = 0;
    ack_auto = 0; ack_man = 0; auto_ack = 0; ack_delay = 1; req_w = 0;
    prev_en = 0; prev_sel = 0;
    gap_c = 0; set_c = 0; meas_c = 0; done_c = 0; busy_c = 0; req_seen = 0; bbm_err = 0;
    repeat (3) tick();
    check_eq("rst_sel", sel, 0);
    check_eq("rst_outs", {sel_en, meas_req, ch_done, busy, done}, 0);
    check_eq("rst_ch_idx", ch_idx, 0);
    rst_n = 1'b1;
    tick();

    // Basic sweep 0..3, settle 2, ack on the first MEAS cycle.
    start_sweep(5'd0, 5'd3, 8'd2, 1'b0, 1);
    check_eq("t1_gap_busy", busy, 1);
    check_eq("t1_gap_en", sel_en, 0);
    check_eq("t1_gap_sel", sel, 0);
    wait_done("t1", 100);
    exp_q = {0, 1, 2, 3};
    check_got("t1");
    for (int i = 0; i < tim_q.size(); i++) check_eq("t1_timing", tim_q[i], {8'd1, 8'd3, 8'd1});
    check_eq("t1_end_busy", busy, 0);
    check_eq("t1_end_en", sel_en, 0);
    check_eq("t1_end_sel", sel, 3);
    check_eq("t1_bbm", bbm_err, 0);

    // Wrapping range 30..1.
    start_sweep(5'd30, 5'd1, 8'd1, 1'b0, 2);
    wait_done("t2", 100);
    exp_q = {30, 31, 0, 1};
    check_got("t2");
    check_eq("t2_end_busy", busy, 0);

    // Continuous single channel, stopped during MEAS.
    start_sweep(5'd5, 5'd5, 8'd0, 1'b1, 4);
    n = 0;
    while (got_q.size() < 3 && n < 200) begin tick(); n++; end
    check_eq("t3_repeats", got_q.size() >= 3, 1);
    check_eq("t3_no_done", done_c, 0);
    n = 0;
    while (!meas_req && n < 20) begin tick(); n++; end
    check_eq("t3_in_meas", meas_req, 1);
    base = got_q.size();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("t3", 50);
    check_eq("t3_final_len", got_q.size(), base + 1);
    for (int i = 0; i < got_q.size(); i++) check_eq("t3_idx", got_q[i], 5);
    check_eq("t3_end_busy", busy, 0);
    check_eq("t3_end_en", sel_en, 0);

    // Stop during SETTLE of channel 2.
    start_sweep(5'd0, 5'd7, 8'd3, 1'b0, 1);
    n = 0;
    while (!(sel == 2 && sel_en && !meas_req) && n < 100) begin tick(); n++; end
    check_eq("t4_in_settle", {sel_en, meas_req}, 2'b10);
    base = req_seen;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("t4_abort_busy", busy, 0);
    check_eq("t4_abort_done", done, 1);
    check_eq("t4_abort_en", sel_en, 0);
    check_eq("t4_abort_chdone", ch_done, 0);
    repeat (5) tick();
    exp_q = {0, 1};
    check_got("t4");
    check_eq("t4_no_req", req_seen, base);
    check_eq("t4_done_cnt", done_c, 1);

    // Ack in IDLE, start+stop in IDLE.
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check_eq("t5_idle_ack", {ch_done, busy, meas_req}, 0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_eq("t5_start_stop", busy, 0);

    // Ack during SETTLE and start while busy are both ignored.
    start_sweep(5'd10, 5'd11, 8'd5, 1'b0, 1);
    repeat (2) tick();
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check_eq("t5_settle_ack", {ch_done, meas_req}, 0);
    ch_first = 5'd20; ch_last = 5'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t5_busy_start", busy, 1);
    wait_done("t5", 100);
    exp_q = {10, 11};
    check_got("t5");
    check_eq("t5_settle_len", tim_q[0], {8'd1, 8'd6, 8'd1});

    // Asynchronous reset during MEAS.
    start_sweep(5'd9, 5'd12, 8'd0, 1'b0, 1);
    auto_ack = 1'b0;
    n = 0;
    while (!meas_req && n < 20) begin tick(); n++; end
    check_eq("t6_pre_req", meas_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_req", meas_req, 0);
    check_eq("t6_rst_en", sel_en, 0);
    check_eq("t6_rst_sel", sel, 0);
    check_eq("t6_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_en = 1'b0;
    tick();

    // Full 0..31 sweep with settle 0 under the break-before-make monitor.
    start_sweep(5'd0, 5'd31, 8'd0, 1'b0, 1);
    wait_done("t7", 300);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(i);
    check_got("t7");
    for (int i = 0; i < tim_q.size(); i++) check_eq("t7_timing", tim_q[i], {8'd1, 8'd1, 8'd1});
    check_eq("t7_busy_cycles", busy_c, 96);
    check_eq("t7_bbm", bbm_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
